// File: rtl/imm_ext_seq_if.sv
// imm_ext_seq_if: handshake bundle for the immediate-extension unit.
//
// Valid/ready semantics on both channels: a transfer happens on a rising
// clock edge where valid and ready are both 1. A producer holds its payload
// stable while valid is high and ready is low. Ready may be asserted without
// valid.
//
// Signals:
//   in_valid/in_ready      - decode -> unit request channel
//   in_mode                - 00 SEXT, 01 ZEXT, 10 SHL, 11 PREFIX
//   in_data, in_shamt      - immediate field and SHL shift amount
//   out_valid/out_ready    - unit -> ALU operand channel
//   out_data, out_ovf      - extended operand and lost-bits flag
//
// master: the side driving requests and consuming results (decode/ALU).
// slave : the extension unit itself.
interface imm_ext_seq_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8,
  parameter int SH_W  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [IN_W-1:0]  in_data;
  logic [SH_W-1:0]  in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_mode, in_data, in_shamt, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_shamt, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/imm_ext_seq.sv
// imm_ext_seq: registered immediate-extension unit.
//
// Takes IN_W-bit immediate fields and produces OUT_W-bit operands in
// sign-extend, zero-extend or shift-left mode. PREFIX ops accumulate narrow
// fields into a wider immediate that the next non-PREFIX op consumes.
//
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   clr  - synchronous discard of any pending prefix (output reg untouched)
//   bus  - imm_ext_seq_if.slave request/result handshake
module imm_ext_seq #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8,
  parameter int SH_W  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  imm_ext_seq_if.slave  bus
);

  localparam logic [1:0] MODE_SEXT = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_PFX  = 2'b11;

  // Chunks needed to fill OUT_W; the count saturates here.
  localparam int CMAX  = (OUT_W + IN_W - 1) / IN_W;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int VW    = OUT_W + IN_W;
  localparam int SHL_W = OUT_W + (1 << SH_W);
  localparam logic [CW-1:0] CNT_MAX = CW'(CMAX);

  logic [OUT_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             pov;

  logic [OUT_W-1:0] out_data_q;
  logic             out_ovf_q;
  logic             out_valid_q;

  // Prefix state as seen by this cycle's op (clr wipes it first).
  logic [OUT_W-1:0] acc_base;
  logic [CW-1:0]    cnt_base;
  logic             pov_base;

  logic [VW-1:0]    v;
  int               ew;
  logic             sbit;
  logic [OUT_W-1:0] ext;
  logic [SHL_W-1:0] shl_wide;
  logic             hi_lost;
  logic [OUT_W-1:0] res_data;
  logic             res_ovf;
  logic [OUT_W-1:0] acc_pfx;
  logic             pov_pfx;
  logic [CW-1:0]    cnt_pfx;

  logic accept;
  logic is_pfx;

  // in_ready depends only on the output register and out_ready.
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign is_pfx = (bus.in_mode == MODE_PFX);

  always_comb begin
    acc_base = clr ? '0 : acc;
    cnt_base = clr ? '0 : cnt;
    pov_base = clr ? 1'b0 : pov;

    // (acc << IN_W) | in_data without truncation.
    v = {acc_base, bus.in_data};

    // Only the bits actually supplied by prefix chunks plus this field count.
    ew = IN_W * (int'(cnt_base) + 1);
    if (ew > OUT_W) ew = OUT_W;

    sbit = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i == ew - 1) sbit = v[i];
    end

    ext = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i < ew)                         ext[i] = v[i];
      else if (bus.in_mode == MODE_SEXT)  ext[i] = sbit;
      else                                ext[i] = 1'b0;
    end

    // Wide enough that no shift amount can push bits off the top.
    shl_wide = SHL_W'(ext) << bus.in_shamt;

    // Bits of V above OUT_W-1 are exactly the top IN_W bits of the old acc.
    hi_lost = |v[VW-1:OUT_W];

    res_data = ext;
    res_ovf  = pov_base | hi_lost;
    if (bus.in_mode == MODE_SHL) begin
      res_data = shl_wide[OUT_W-1:0];
      res_ovf  = pov_base | hi_lost | (|shl_wide[SHL_W-1:OUT_W]);
    end

    acc_pfx = v[OUT_W-1:0];
    pov_pfx = pov_base | hi_lost;
    cnt_pfx = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CW'(1);
  end

  // Prefix accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      pov <= 1'b0;
    end else if (accept && is_pfx) begin
      acc <= acc_pfx;
      cnt <= cnt_pfx;
      pov <= pov_pfx;
    end else if (accept || clr) begin
      // A non-PREFIX op consumes the prefix; clr alone discards it.
      acc <= '0;
      cnt <= '0;
      pov <= 1'b0;
    end
  end

  // Output register: reload wins over drain so back-to-back ops keep valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept && !is_pfx) begin
      out_data_q  <= res_data;
      out_ovf_q   <= res_ovf;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_ext_seq.sv
// tb_imm_ext_seq: directed-vector bench for imm_ext_seq (IN_W=5, OUT_W=8).
// Driver tasks push hand-computed {ovf,data} results into exp_q; a monitor
// pops and compares on every output transfer.
module tb_imm_ext_seq;

  localparam logic [1:0] SEXT = 2'b00;
  localparam logic [1:0] ZEXT = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] PFX  = 2'b11;

  logic clk;
  logic rst;
  logic clr;

  imm_ext_seq_if #(.IN_W(5), .OUT_W(8), .SH_W(3)) bus ();

  imm_ext_seq #(.IN_W(5), .OUT_W(8), .SH_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus.slave)
  );

  logic [8:0] exp_q[$];
  int vecs  = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    vecs++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        vecs++;
        fails++;
        $display("FAIL unexpected_output: got %h expected none", {bus.out_ovf, bus.out_data});
      end else begin
        check("result", {bus.out_ovf, bus.out_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [1:0] mode, input logic [4:0] data,
                      input logic [2:0] sh, input logic c, input logic [8:0] exp);
    int  waits = 0;
    bit  done  = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_data  = data;
    bus.in_shamt = sh;
    clr          = c;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (mode != PFX) exp_q.push_back(exp);
        done = 1;
      end else if (waits >= 50) begin
        vecs++;
        fails++;
        $display("FAIL send_timeout: in_ready 0 expected 1");
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    clr          = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {8'h00, bus.out_valid}, 9'h000);
    check({tag, "_out_data"},  {1'b0, bus.out_data},   9'h000);
    check({tag, "_out_ovf"},   {8'h00, bus.out_ovf},   9'h000);
    check({tag, "_in_ready"},  {8'h00, bus.in_ready},  9'h001);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = SEXT;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Basic extension.
    send(SEXT, 5'b10101, 3'd0, 1'b0, 9'h0F5);
    send(ZEXT, 5'b10101, 3'd0, 1'b0, 9'h015);
    send(SEXT, 5'b01111, 3'd0, 1'b0, 9'h00F);

    // Prefix combine.
    send(PFX,  5'b00011, 3'd0, 1'b0, 9'h000);
    send(SEXT, 5'b10101, 3'd0, 1'b0, 9'h075);
    send(PFX,  5'b11111, 3'd0, 1'b0, 9'h000);
    send(ZEXT, 5'b00001, 3'd0, 1'b0, 9'h1E1);
    send(SEXT, 5'b10101, 3'd0, 1'b0, 9'h0F5);
    // Two prefixes saturate the count; top bits 3'b100 fall off -> ovf.
    send(PFX,  5'b00001, 3'd0, 1'b0, 9'h000);
    send(PFX,  5'b00010, 3'd0, 1'b0, 9'h000);
    send(ZEXT, 5'b00011, 3'd0, 1'b0, 9'h143);

    // Shift.
    send(SHL, 5'b00011, 3'd3, 1'b0, 9'h018);
    send(SHL, 5'b11000, 3'd4, 1'b0, 9'h180);
    send(SHL, 5'b00001, 3'd7, 1'b0, 9'h080);
    send(SHL, 5'b00001, 3'd0, 1'b0, 9'h001);
    idle(3);

    // Backpressure.
    bus.out_ready = 1'b0;
    send(SEXT, 5'b10101, 3'd0, 1'b0, 9'h0F5);
    fork
      send(ZEXT, 5'b00001, 3'd0, 1'b0, 9'h001);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_hold_data", {bus.out_ovf, bus.out_data}, 9'h0F5);
          check("bp_in_ready", {8'h00, bus.in_ready}, 9'h000);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(3);

    // Reset mid-sequence discards the pending prefix.
    send(PFX, 5'b00011, 3'd0, 1'b0, 9'h000);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(SEXT, 5'b10101, 3'd0, 1'b0, 9'h0F5);
    idle(2);

    // clr collides with a PREFIX: the old prefix (and its overflow) is gone.
    send(PFX,  5'b11111, 3'd0, 1'b0, 9'h000);
    send(PFX,  5'b00011, 3'd0, 1'b1, 9'h000);
    send(SEXT, 5'b10101, 3'd0, 1'b0, 9'h075);
    // clr with a non-PREFIX op: evaluated as if no prefix.
    send(PFX,  5'b11111, 3'd0, 1'b0, 9'h000);
    send(ZEXT, 5'b00001, 3'd0, 1'b1, 9'h001);
    idle(2);

    // clr alone leaves a held result untouched.
    bus.out_ready = 1'b0;
    send(SEXT, 5'b01111, 3'd0, 1'b0, 9'h00F);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_hold_data", {bus.out_ovf, bus.out_data}, 9'h00F);
    check("clr_hold_valid", {8'h00, bus.out_valid}, 9'h001);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Drain.
    begin
      int budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      @(negedge clk);
      if (exp_q.size() != 0) begin
        vecs++;
        fails++;
        $display("FAIL drain: %0d results outstanding expected 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
